// File: rtl/apb_cmd_master_if.sv
// Command, response and APB bus bundle for apb_cmd_master.
// master = requester side, slave = sequencer/peripheral side.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pready_i;
  logic              pslverr_i;
  logic [DATA_W-1:0] prdata_i;

  modport master (
    input  cmd_valid_i, cmd_op_i,
    input  cmd_addr_i, cmd_wdata_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o,
    output rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output psel_o, penable_o, pwrite_o,
    output paddr_o, pwdata_o,
    input  pready_i, pslverr_i, prdata_i
  );

  modport slave (
    output cmd_valid_i, cmd_op_i,
    output cmd_addr_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o,
    input  rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  psel_o, penable_o, pwrite_o,
    input  paddr_o, pwdata_o,
    output pready_i, pslverr_i, prdata_i
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 requester: read / write / read-increment-write commands,
// with PSLVERR reporting and a wait-state timeout.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter logic [DATA_W-1:0] INC = DATA_W'(1)
) (
  input  logic clk,
  input  logic reset,
  apb_cmd_master_if.master bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RMW = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              wph_q, wph_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              tmo_hit;

  // This stalled cycle is the TIMEOUT-th wait state.
  assign tmo_hit = (TIMEOUT != 0) && !bus.pready_i &&
                   (32'(wcnt_q) + 32'd1 == 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wph_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      wph_q    <= wph_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    wph_d    = wph_q;
    wcnt_d   = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          op_d    = bus.cmd_op_i;
          rdata_d = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          wph_d   = 1'b0;
          if (bus.cmd_op_i == OP_RSV) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            addr_d   = bus.cmd_addr_i;
            pwdata_d = bus.cmd_wdata_i;
            pwrite_d = (bus.cmd_op_i == OP_WR);
            state_d  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        wcnt_d  = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.pready_i) begin
          if (!wph_q && op_q != OP_WR) begin
            rdata_d = bus.prdata_i;
          end
          if (op_q == OP_RMW && !wph_q && !bus.pslverr_i) begin
            wph_d    = 1'b1;
            pwrite_d = 1'b1;
            pwdata_d = bus.prdata_i + INC;
            state_d  = S_SETUP;
          end else begin
            err_d   = bus.pslverr_i;
            state_d = S_RESP;
          end
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready_o   = (state_q == S_IDLE);
    bus.rsp_valid_o   = (state_q == S_RESP);
    bus.rsp_rdata_o   = rdata_q;
    bus.rsp_err_o     = err_q;
    bus.rsp_timeout_o = tmo_q;
    bus.psel_o        = (state_q == S_SETUP) ||
                        (state_q == S_ACCESS);
    bus.penable_o     = (state_q == S_ACCESS);
    bus.pwrite_o      = pwrite_q;
    bus.paddr_o       = addr_q;
    bus.pwdata_o      = pwdata_q;
  end

endmodule
